// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - byte-addressed load/store front end for a word-wide BRAM
module lsu_mem_if #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_pc,
    output logic [3:0]  mem_w_enable,
    output logic [31:0] mem_r_addr,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data,
    output logic [31:0] mem_row_addr,
    input  logic [31:0] mem_r_data
);

    typedef enum logic [2:0] {IDLE, LD_HI, LD_RESP, ST_HI, ST_RESP} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             pc_q, pc_d;
    logic [31:0]             lo_q, lo_d;
    logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;

    // Lanes 4..7 of the mask belong to the following word.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            default: base = 8'h0F;
        endcase
        return base << off;
    endfunction

    logic [7:0]            req_mask, q_mask;
    logic [ADDR_WIDTH-1:0] req_w, q_w, q_w_inc;
    logic                  q_cross;
    logic [63:0]           ld_pair;
    logic [31:0]           ld_word;
    logic [31:0]           ld_result;
    logic [3:0]            w_en;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [31:0]           w_data;
    logic                  ready, rvalid;
    logic [31:0]           rdata;

    assign req_mask = lane_mask(req_size, req_addr[1:0]);
    assign q_mask   = lane_mask(size_q, addr_q[1:0]);
    assign req_w    = req_addr[ADDR_WIDTH+1:2];
    assign q_w      = addr_q[ADDR_WIDTH+1:2];
    assign q_w_inc  = q_w + ADDR_WIDTH'(1);
    assign q_cross  = |q_mask[7:4];

    assign ld_pair = q_cross ? {mem_r_data, lo_q} : {32'h0, mem_r_data};
    assign ld_word = 32'(ld_pair >> {addr_q[1:0], 3'b000});

    always_comb begin
        ld_result = ld_word;
        case (size_q)
            2'd0: ld_result = uns_q ? {24'h0, ld_word[7:0]}  : {{24{ld_word[7]}},  ld_word[7:0]};
            2'd1: ld_result = uns_q ? {16'h0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
            default: ld_result = ld_word;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        pc_d    = pc_q;
        lo_d    = lo_q;
        raddr_d = raddr_q;
        ready   = 1'b0;
        rvalid  = 1'b0;
        rdata   = 32'h0;
        w_en    = 4'h0;
        w_addr  = q_w;
        w_data  = 32'h0;
        case (state_q)
            IDLE: begin
                ready  = 1'b1;
                w_addr = req_w;
                w_data = req_wdata << {req_addr[1:0], 3'b000};
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    if (req_we) begin
                        w_en    = req_mask[3:0];
                        state_d = (|req_mask[7:4]) ? ST_HI : ST_RESP;
                    end else begin
                        raddr_d = req_w;
                        state_d = (|req_mask[7:4]) ? LD_HI : LD_RESP;
                    end
                end
            end
            LD_HI: begin
                raddr_d = q_w_inc;
                lo_d    = mem_r_data;
                state_d = LD_RESP;
            end
            LD_RESP: begin
                rvalid  = 1'b1;
                rdata   = ld_result;
                state_d = IDLE;
            end
            ST_HI: begin
                w_addr  = q_w_inc;
                w_en    = 4'(q_mask >> 4);
                w_data  = wdata_q >> {3'd4 - {1'b0, addr_q[1:0]}, 3'b000};
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rvalid  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset must also suppress the second half of an in-flight store.
        if (rst) begin
            ready  = 1'b0;
            rvalid = 1'b0;
            rdata  = 32'h0;
            w_en   = 4'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            raddr_q <= raddr_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        wdata_q <= wdata_d;
        pc_q    <= pc_d;
        lo_q    <= lo_d;
    end

    assign req_ready    = ready;
    assign resp_valid   = rvalid;
    assign resp_rdata   = rdata;
    assign mem_w_enable = w_en;
    assign mem_r_addr   = 32'(raddr_d);
    assign mem_w_addr   = 32'(w_addr);
    assign mem_w_data   = w_data;
    assign mem_row_addr = addr_q;
    assign mem_pc       = pc_q;

endmodule
